mem_ctrl_arb: RTL and testbench
===============================

Name: mem_ctrl_arb

Overview:
Parametrised byte-serial RAM controller. It arbitrates between the instruction-fetch port (from i-cache) and the load/store port (from MEM) onto a single 8-bit RAM bus. It pipelines byte reads over a configurable RAM read latency and sign/zero-extends sub-word loads. It stalls only IO-region writes on io_buffer_full, and supports aborting an in-flight fetch.

Parameters:
ADDR_W, 32, address width of if_addr, ls_addr, mem_a
XLEN, 32, data word width; must be 32 or 64; DATA_BYTES = XLEN/8
IF_BYTES, 4, bytes per instruction fetch (1..DATA_BYTES)
RD_LAT, 1, cycles from mem_a presented to matching byte valid on mem_din (1..3)
IO_BASE, 32'h30000, addresses >= IO_BASE are the IO region

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch request, level; held until if_done or dropped via if_abort
if_addr  in  ADDR_W  fetch byte address
if_abort  in  1  cancel pending/in-flight fetch (branch flush)
if_done  out  1  one-cycle pulse: if_data valid
if_data  out  8*IF_BYTES  fetched instruction, little-endian
ls_req  in  1  load/store request, level; held stable until ls_done
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  data byte address
ls_wdata  in  XLEN  store data
ls_len  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = 8 bytes
ls_signed  in  1  1 = sign-extend load, 0 = zero-extend
ls_done  out  1  one-cycle pulse: store complete / ls_rdata valid
ls_rdata  out  XLEN  extended load result
mem_din  in  8  RAM read data
io_buffer_full  in  1  IO write buffer full
mem_dout  out  8  RAM write data
mem_a  out  ADDR_W  RAM address
mem_wr  out  1  RAM write enable

Behaviour:
- Reset (sync): state IDLE; if_done=0, ls_done=0, if_data=0, ls_rdata=0, mem_a=0, mem_dout=0, mem_wr=0; byte counters and capture buffer cleared. rst mid-operation abandons the transfer; no done pulse is issued.
- States: IDLE, RD, WR, DONE.
- IDLE: mem_a=0, mem_wr=0, mem_dout=0. Arbitration at the clock edge: ls_req has priority over if_req. if_req is ignored when if_abort is high.
- Byte count n: ls path uses 1<<ls_len; if that exceeds DATA_BYTES it is treated as DATA_BYTES. Fetch path uses IF_BYTES. Addresses are base+i, i = 0..n-1, computed mod 2^ADDR_W (wraps).
- RD: issue counter drives mem_a = base+i in consecutive cycles i = 0..n-1, with mem_wr=0. Capture counter stores mem_din into byte j during the cycle j+RD_LAT after issue cycle 0.
- RD timing: after the last capture, go to DONE. Accept edge to done cycle is n+RD_LAT+1 cycles (word load, RD_LAT=1: done in 6th cycle after accept). After the issue phase ends and before DONE, mem_a=0.
- Load extension: bytes above n are filled with byte n-1 bit 7 when ls_signed=1, else zero. A full-width load is unchanged.
- WR: each cycle drives mem_a = base+i, mem_dout = ls_wdata byte i, mem_wr=1, then advances i. If io_buffer_full=1 and base+i >= IO_BASE, it drives mem_wr=0 and holds i (stall, no limit). Non-IO writes ignore io_buffer_full. After byte n-1 is written, go to DONE. Unstalled latency is n+1 cycles.
- DONE (one cycle): pulse the matching done with the data register valid. if_data / ls_rdata hold their value until the next completion of the same port. New requests are not sampled in DONE; the requester must drop or replace its req by the end of the DONE cycle. Return to IDLE afterwards.
- if_abort during a fetch RD: stop issuing, return to IDLE at the next edge, no if_done. In-flight read bytes are discarded. Abort has no effect on ls transfers.
- Requests stay pending while another transfer runs; no queueing beyond the held level.

Test Plan:
1. Load word, ls_addr=0x100, RAM bytes 11,22,33,44, RD_LAT=1 -> mem_a 0x100..0x103 in cycles 1-4; ls_done in cycle 6; ls_rdata=0x44332211.
2. Signed byte load of 0x80 -> ls_rdata=0xFFFFFF80. Unsigned -> 0x00000080. Signed half 0x7FFF -> 0x00007FFF.
3. Store word 0xDEADBEEF to IO_BASE with io_buffer_full high for 3 cycles after byte 1 -> writes EF, BE (3-cycle stall, mem_wr=0), AD, DE; ls_done 3 cycles later than unstalled. Same store to 0x200 with full high -> no stall.
4. if_req and ls_req both asserted in the same cycle -> load served first; fetch accepted the cycle after DONE; if_done carries the correct instruction.
5. Fetch in progress, if_abort at byte 2 -> next cycle IDLE, mem_a=0, no if_done; new fetch then completes normally. rst asserted mid-store -> no further mem_wr, no ls_done.
6. RD_LAT=3, XLEN=64, ls_len=3 at address 0xFFFFFFFC -> addresses wrap to 0x0..0x3; ls_done at cycle 8+3+1=12.

Source files
------------

// File: rtl/mem_ctrl_arb_if.sv
// rtl/mem_ctrl_arb_if.sv - fetch, load/store and byte-serial RAM bus bundle for mem_ctrl_arb
interface mem_ctrl_arb_if #(
   parameter int ADDR_W   = 32,
   parameter int XLEN     = 32,
   parameter int IF_BYTES = 4
);
   logic                    if_req;
   logic [ADDR_W-1:0]       if_addr;
   logic                    if_abort;
   logic                    if_done;
   logic [8*IF_BYTES-1:0]   if_data;
   logic                    ls_req;
   logic                    ls_we;
   logic [ADDR_W-1:0]       ls_addr;
   logic [XLEN-1:0]         ls_wdata;
   logic [1:0]              ls_len;
   logic                    ls_signed;
   logic                    ls_done;
   logic [XLEN-1:0]         ls_rdata;
   logic [7:0]              mem_din;
   logic                    io_buffer_full;
   logic [7:0]              mem_dout;
   logic [ADDR_W-1:0]       mem_a;
   logic                    mem_wr;

   modport master (
      output if_req, if_addr, if_abort, ls_req, ls_we, ls_addr, ls_wdata, ls_len, ls_signed,
             mem_din, io_buffer_full,
      input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
   );

   modport slave (
      input  if_req, if_addr, if_abort, ls_req, ls_we, ls_addr, ls_wdata, ls_len, ls_signed,
             mem_din, io_buffer_full,
      output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_ctrl_arb.sv
// rtl/mem_ctrl_arb.sv - byte-serial RAM controller arbitrating fetch and load/store ports
module mem_ctrl_arb #(
   parameter int                ADDR_W   = 32,
   parameter int                XLEN     = 32,
   parameter int                IF_BYTES = 4,
   parameter int                RD_LAT   = 1,
   parameter logic [ADDR_W-1:0] IO_BASE  = 'h30000
) (
   input  logic            clk,
   input  logic            rst,
   mem_ctrl_arb_if.slave   bus
);
   localparam int         DB   = XLEN / 8;
   localparam logic [3:0] LAT  = 4'(RD_LAT);
   localparam logic [3:0] DB4  = 4'(DB);
   localparam logic [3:0] IFB4 = 4'(IF_BYTES);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
   state_t state, state_nx;

   logic [3:0]            cyc, n, ls_n, cap_idx;
   logic                  is_ls, sgn, sign_bit;
   logic [ADDR_W-1:0]     base, cur_a;
   logic [XLEN-1:0]       buf_q, cap_word, ext_word, ls_rdata_q;
   logic [8*IF_BYTES-1:0] if_data_q;
   logic                  abort_rd, cap_en, rd_last, stall;
   logic [ADDR_W-1:0]     mem_a;
   logic [7:0]            mem_dout;
   logic                  mem_wr, if_done, ls_done;

   always_comb begin
      ls_n = 4'd1 << bus.ls_len;
      if (ls_n > DB4) ls_n = DB4;
   end

   // One cycle counter serves both the issue index (cyc) and the capture index (cyc - RD_LAT).
   assign cur_a    = base + ADDR_W'(cyc);
   assign abort_rd = (state == RD) && !is_ls && bus.if_abort;
   assign cap_en   = (state == RD) && (cyc >= LAT);
   assign cap_idx  = cyc - LAT;
   assign rd_last  = (cyc == n - 4'd1 + LAT);
   assign stall    = bus.io_buffer_full && (cur_a >= IO_BASE);

   always_comb begin
      cap_word = buf_q;
      for (int k = 0; k < DB; k++)
         if (cap_en && cap_idx == 4'(k)) cap_word[8*k +: 8] = bus.mem_din;
   end

   always_comb begin
      sign_bit = 1'b0;
      for (int k = 0; k < DB; k++)
         if (n == 4'(k + 1)) sign_bit = cap_word[8*k + 7];
      for (int k = 0; k < DB; k++)
         ext_word[8*k +: 8] = (4'(k) < n) ? cap_word[8*k +: 8] : {8{sgn & sign_bit}};
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (bus.ls_req)                       state_nx = bus.ls_we ? WR : RD;
            else if (bus.if_req && !bus.if_abort) state_nx = RD;
         end
         RD: begin
            if (abort_rd)     state_nx = IDLE;
            else if (rd_last) state_nx = DONE;
         end
         WR:      if (!stall && cyc == n - 4'd1) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      mem_a    = '0;
      mem_dout = '0;
      mem_wr   = 1'b0;
      if_done  = 1'b0;
      ls_done  = 1'b0;
      case (state)
         RD: if (cyc < n && !abort_rd) mem_a = cur_a;
         WR: begin
            mem_a  = cur_a;
            mem_wr = !stall;
            for (int k = 0; k < DB; k++)
               if (cyc == 4'(k)) mem_dout = bus.ls_wdata[8*k +: 8];
         end
         DONE: begin
            if_done = !is_ls;
            ls_done = is_ls;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc        <= '0;
         n          <= '0;
         is_ls      <= 1'b0;
         sgn        <= 1'b0;
         base       <= '0;
         buf_q      <= '0;
         if_data_q  <= '0;
         ls_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               cyc   <= '0;
               buf_q <= '0;
               if (bus.ls_req) begin
                  is_ls <= 1'b1;
                  base  <= bus.ls_addr;
                  n     <= ls_n;
                  sgn   <= bus.ls_signed;
               end else if (bus.if_req && !bus.if_abort) begin
                  is_ls <= 1'b0;
                  base  <= bus.if_addr;
                  n     <= IFB4;
                  sgn   <= 1'b0;
               end
            end
            RD: begin
               buf_q <= cap_word;
               cyc   <= cyc + 4'd1;
               // The last byte arrives on the edge into DONE, so results are built from cap_word.
               if (rd_last && !abort_rd) begin
                  if (is_ls) ls_rdata_q <= ext_word;
                  else       if_data_q  <= cap_word[8*IF_BYTES-1:0];
               end
            end
            WR:      if (!stall) cyc <= cyc + 4'd1;
            default: cyc <= '0;
         endcase
      end
   end

   assign bus.mem_a    = mem_a;
   assign bus.mem_dout = mem_dout;
   assign bus.mem_wr   = mem_wr;
   assign bus.if_done  = if_done;
   assign bus.ls_done  = ls_done;
   assign bus.if_data  = if_data_q;
   assign bus.ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_ctrl_arb.sv
// tb/tb_mem_ctrl_arb.sv - directed scoreboard bench for mem_ctrl_arb
module tb_mem_ctrl_arb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_ctrl_arb_if #(.ADDR_W(32), .XLEN(32), .IF_BYTES(4)) bus_a ();
   mem_ctrl_arb_if #(.ADDR_W(32), .XLEN(64), .IF_BYTES(4)) bus_b ();

   mem_ctrl_arb #(.ADDR_W(32), .XLEN(32), .IF_BYTES(4), .RD_LAT(1), .IO_BASE(32'h30000))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   mem_ctrl_arb #(.ADDR_W(32), .XLEN(64), .IF_BYTES(4), .RD_LAT(3), .IO_BASE(32'h30000))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   typedef struct {
      bit          ld;
      logic [63:0] d;
   } sb_t;

   sb_t         exp_ls[$];
   logic [63:0] exp_if[$];
   logic [7:0]  ram [logic [31:0]];

   int vectors = 0;
   int miscompares = 0;
   int lat_ls, lat_if, n_lsd, n_ifd, lat_b, wr_after;
   logic [31:0] tr_a  [0:31];
   logic        tr_wr [0:31];
   logic [7:0]  tr_do [0:31];
   logic [7:0]  s1_b, s2_b;
   logic [63:0] exp64, last_if;
   logic [31:0] a_tmp;

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return a[7:0] ^ 8'hA5;
   endfunction

   function automatic logic [63:0] fetch_word(input logic [31:0] a);
      logic [63:0] w = '0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = ram_rd(a + 32'(i));
      return w;
   endfunction

   // RAM read pipelines: RD_LAT=1 for bus_a, RD_LAT=3 for bus_b.
   always @(posedge clk) begin
      bus_a.mem_din <= ram_rd(bus_a.mem_a);
      s1_b          <= ram_rd(bus_b.mem_a);
      s2_b          <= s1_b;
      bus_b.mem_din <= s2_b;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_a(input int max, input int full_from, input int full_len,
                        input int abort_at, input int rst_at);
      sb_t         e;
      logic [63:0] ei;
      lat_ls = 0; lat_if = 0; n_lsd = 0; n_ifd = 0;
      for (int k = 1; k <= max; k++) begin
         @(negedge clk);
         bus_a.io_buffer_full = (k >= full_from) && (k < full_from + full_len);
         bus_a.if_abort = (k == abort_at);
         if (k == abort_at) bus_a.if_req = 1'b0;
         rst = (k == rst_at);
         if (k == rst_at) bus_a.ls_req = 1'b0;
         #1;
         tr_a[k]  = bus_a.mem_a;
         tr_wr[k] = bus_a.mem_wr;
         tr_do[k] = bus_a.mem_dout;
         if (bus_a.ls_done) begin
            n_lsd++;
            if (lat_ls == 0) lat_ls = k;
            if (exp_ls.size() == 0) check("ls_unexpected_done", 64'(bus_a.ls_done), 64'd0);
            else begin
               e = exp_ls.pop_front();
               if (e.ld) check("ls_rdata", 64'(bus_a.ls_rdata), e.d);
            end
            bus_a.ls_req = 1'b0;
         end
         if (bus_a.if_done) begin
            n_ifd++;
            if (lat_if == 0) lat_if = k;
            if (exp_if.size() == 0) check("if_unexpected_done", 64'(bus_a.if_done), 64'd0);
            else begin
               ei = exp_if.pop_front();
               check("if_data", 64'(bus_a.if_data), ei);
            end
            bus_a.if_req = 1'b0;
         end
      end
      bus_a.io_buffer_full = 1'b0;
      bus_a.if_abort = 1'b0;
   endtask

   task automatic start_ls(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] len, input logic sgn);
      bus_a.ls_we = we; bus_a.ls_addr = addr; bus_a.ls_wdata = wdata;
      bus_a.ls_len = len; bus_a.ls_signed = sgn; bus_a.ls_req = 1'b1;
   endtask

   initial begin
      bus_a.if_req = 0; bus_a.if_addr = 0; bus_a.if_abort = 0; bus_a.ls_req = 0; bus_a.ls_we = 0;
      bus_a.ls_addr = 0; bus_a.ls_wdata = 0; bus_a.ls_len = 0; bus_a.ls_signed = 0;
      bus_a.io_buffer_full = 0;
      bus_b.if_req = 0; bus_b.if_addr = 0; bus_b.if_abort = 0; bus_b.ls_req = 0; bus_b.ls_we = 0;
      bus_b.ls_addr = 0; bus_b.ls_wdata = 0; bus_b.ls_len = 0; bus_b.ls_signed = 0;
      bus_b.io_buffer_full = 0;
      ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
      ram[32'h180] = 8'h80; ram[32'h190] = 8'hFF; ram[32'h191] = 8'h7F;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_mem_a", 64'(bus_a.mem_a), 64'd0);
      check("rst_mem_wr", 64'(bus_a.mem_wr), 64'd0);
      check("rst_mem_dout", 64'(bus_a.mem_dout), 64'd0);
      check("rst_dones", 64'({bus_a.if_done, bus_a.ls_done}), 64'd0);
      check("rst_ls_rdata", 64'(bus_a.ls_rdata), 64'd0);
      check("rst_if_data", 64'(bus_a.if_data), 64'd0);

      // word load, RD_LAT=1
      start_ls(1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
      exp_ls.push_back('{ld: 1'b1, d: 64'h44332211});
      run_a(10, 0, 0, 0, 0);
      check("word_lat", 64'(lat_ls), 64'd6);
      for (int i = 1; i <= 4; i++) check("word_mem_a", 64'(tr_a[i]), 64'(32'h100 + 32'(i - 1)));
      check("word_mem_a_tail", 64'(tr_a[5]), 64'd0);
      check("word_mem_wr", 64'(tr_wr[2]), 64'd0);

      // sub-word loads and extension
      start_ls(1'b0, 32'h180, 32'h0, 2'd0, 1'b1);
      exp_ls.push_back('{ld: 1'b1, d: 64'hFFFFFF80});
      run_a(6, 0, 0, 0, 0);
      check("sbyte_lat", 64'(lat_ls), 64'd3);
      start_ls(1'b0, 32'h180, 32'h0, 2'd0, 1'b0);
      exp_ls.push_back('{ld: 1'b1, d: 64'h00000080});
      run_a(6, 0, 0, 0, 0);
      start_ls(1'b0, 32'h190, 32'h0, 2'd1, 1'b1);
      exp_ls.push_back('{ld: 1'b1, d: 64'h00007FFF});
      run_a(7, 0, 0, 0, 0);
      check("shalf_lat", 64'(lat_ls), 64'd4);

      // IO store stalled by io_buffer_full in cycles 3..5
      start_ls(1'b1, 32'h30000, 32'hDEADBEEF, 2'd2, 1'b0);
      exp_ls.push_back('{ld: 1'b0, d: 64'd0});
      run_a(12, 3, 3, 0, 0);
      check("io_st_lat", 64'(lat_ls), 64'd8);
      check("io_st_b0", 64'({tr_wr[1], tr_a[1], tr_do[1]}), 64'({1'b1, 32'h30000, 8'hEF}));
      check("io_st_b1", 64'({tr_wr[2], tr_a[2], tr_do[2]}), 64'({1'b1, 32'h30001, 8'hBE}));
      check("io_st_stall_wr", 64'({tr_wr[3], tr_wr[4], tr_wr[5]}), 64'd0);
      check("io_st_stall_a", 64'(tr_a[4]), 64'(32'h30002));
      check("io_st_b2", 64'({tr_wr[6], tr_a[6], tr_do[6]}), 64'({1'b1, 32'h30002, 8'hAD}));
      check("io_st_b3", 64'({tr_wr[7], tr_a[7], tr_do[7]}), 64'({1'b1, 32'h30003, 8'hDE}));

      // non-IO store ignores io_buffer_full
      start_ls(1'b1, 32'h200, 32'hDEADBEEF, 2'd2, 1'b0);
      exp_ls.push_back('{ld: 1'b0, d: 64'd0});
      run_a(8, 3, 3, 0, 0);
      check("mem_st_lat", 64'(lat_ls), 64'd5);
      check("mem_st_b2", 64'({tr_wr[3], tr_a[3], tr_do[3]}), 64'({1'b1, 32'h202, 8'hAD}));

      // simultaneous requests: load first, fetch accepted after DONE
      start_ls(1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
      bus_a.if_addr = 32'h400; bus_a.if_req = 1'b1;
      exp_ls.push_back('{ld: 1'b1, d: 64'h44332211});
      last_if = fetch_word(32'h400);
      exp_if.push_back(last_if);
      run_a(16, 0, 0, 0, 0);
      check("arb_ls_lat", 64'(lat_ls), 64'd6);
      check("arb_if_lat", 64'(lat_if), 64'd13);
      check("arb_if_first_a", 64'(tr_a[8]), 64'(32'h400));

      // fetch aborted while issuing byte 2
      bus_a.if_addr = 32'h500; bus_a.if_req = 1'b1;
      run_a(10, 0, 0, 3, 0);
      check("abort_a1", 64'(tr_a[2]), 64'(32'h501));
      check("abort_idle_a", 64'(tr_a[4]), 64'd0);
      check("abort_no_done", 64'(n_ifd), 64'd0);
      check("abort_if_data_held", 64'(bus_a.if_data), last_if);
      bus_a.if_addr = 32'h600; bus_a.if_req = 1'b1;
      exp_if.push_back(fetch_word(32'h600));
      run_a(9, 0, 0, 0, 0);
      check("refetch_lat", 64'(lat_if), 64'd6);

      // reset in the middle of a store
      start_ls(1'b1, 32'h300, 32'hCAFEF00D, 2'd2, 1'b0);
      run_a(10, 0, 0, 0, 3);
      check("rst_st_b1", 64'(tr_wr[2]), 64'd1);
      wr_after = 0;
      for (int k = 4; k <= 10; k++) if (tr_wr[k]) wr_after++;
      check("rst_st_no_wr", 64'(wr_after), 64'd0);
      check("rst_st_no_done", 64'(n_lsd), 64'd0);
      check("rst_st_rdata_clr", 64'(bus_a.ls_rdata), 64'd0);

      // RD_LAT=3, XLEN=64 doubleword load wrapping past the top of the address space
      exp64 = '0;
      for (int i = 0; i < 8; i++) begin
         a_tmp = 32'hFFFFFFFC + 32'(i);
         exp64[8*i +: 8] = ram_rd(a_tmp);
      end
      bus_b.ls_we = 1'b0; bus_b.ls_addr = 32'hFFFFFFFC; bus_b.ls_len = 2'd3;
      bus_b.ls_signed = 1'b1; bus_b.ls_req = 1'b1;
      lat_b = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         #1;
         tr_a[k] = bus_b.mem_a;
         if (bus_b.ls_done) begin
            if (lat_b == 0) lat_b = k;
            check("b_rdata", bus_b.ls_rdata, exp64);
            bus_b.ls_req = 1'b0;
         end
      end
      check("b_lat", 64'(lat_b), 64'd12);
      check("b_a_top", 64'(tr_a[4]), 64'(32'hFFFFFFFF));
      check("b_a_wrap0", 64'(tr_a[5]), 64'd0);
      check("b_a_wrap3", 64'(tr_a[8]), 64'd3);

      check("sb_ls_drained", 64'(exp_ls.size()), 64'd0);
      check("sb_if_drained", 64'(exp_if.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
